alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all state; rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 9): instruction handshake; in_instr = op[8:6], rd[5:4], ra[3:2], rb[1:0].
REQ-004 SHALL have ports ld_valid (input, 1), ld_addr (input, 2), ld_data (input, 8): direct register load.
REQ-005 SHALL have ports alu_op (output, 3), alu_a (output, 8), alu_b (output, 8): drive the downstream ALU.
REQ-006 SHALL have ports alu_ans (input, 8), alu_zero (input, 1): ALU results, registered in the ALU with 1-cycle latency.
REQ-007 SHALL have ports done (output, 1), done_err (output, 1), zflag (output, 1): completion pulse, illegal-op flag, latched zero flag.
REQ-008 SHALL have ports dbg_addr (input, 2), dbg_data (output, 8): combinational register read.

Function
REQ-009 SHALL hold four 8-bit registers r0..r3.
REQ-010 SHALL implement states IDLE, ISSUE, WB; IDLE->ISSUE on accepted instruction; ISSUE->WB always; WB->IDLE always.
REQ-011 SHALL assert in_ready only in IDLE with ld_valid low; accept = in_valid && in_ready; latch in_instr on accept.
REQ-012 SHALL, in IDLE with ld_valid high, write ld_data to r[ld_addr] at the clock edge; ld has priority over in_valid; ld_valid outside IDLE is ignored.
REQ-013 SHALL, in ISSUE, drive alu_op = latched op, alu_a = r[ra], alu_b = r[rb]; ra == rb is legal.
REQ-014 SHALL, outside ISSUE, drive alu_op = 3'b000 (ADD), alu_a = 0, alu_b = 0.
REQ-015 SHALL, in WB for op in {000,001,010,011,100,110}, write alu_ans to r[rd]; rd may equal ra/rb (the new value is visible from the next cycle).
REQ-016 SHALL, in WB for op 111 (BZ), perform no register write and load zflag with alu_zero.
REQ-017 SHALL treat op 101 as illegal: ALU is still driven per REQ-014 (not the illegal code), no register write, zflag unchanged, done_err = 1 in WB.
REQ-018 SHALL pulse done for exactly one cycle in WB for every accepted instruction; done_err is high only coincident with done.
REQ-019 SHALL give a throughput of one instruction per 3 cycles; the earliest next accept is in the cycle after WB.
REQ-020 SHALL keep zflag unchanged except on BZ writeback and reset.
REQ-021 SHALL make dbg_data = r[dbg_addr] combinationally, reflecting register state after the last clock edge.

Reset
REQ-022 SHALL, with rst high at a clock edge, set state = IDLE, r0..r3 = 0, zflag = 0, done = 0, done_err = 0, and clear the latched instruction.
REQ-023 SHALL give rst priority over all activity; rst asserted in ISSUE or WB aborts the instruction with no write and no done pulse.
REQ-024 SHALL keep in_ready = 0 while rst is high; the first accept is possible in the cycle after rst deasserts.

Structure
REQ-025 SHALL place the ALU opcode constants (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 110, BZ 111, illegal 101) and the state encoding in a shared package used by this block and the ALU.
REQ-026 SHALL implement the register storage as sub-module gpr_file (4x8, 1 write port, 3 combinational read ports: ra, rb, dbg; synchronous reset).
REQ-027 SHALL keep the FSM, instruction latch, and zflag in alu_sequencer.

Verification
REQ-028 SHALL cover this scenario: load r1=5, r2=3; ADD rd=0, ra=1, rb=2 -> in ISSUE alu_op=000, a=5, b=3; done in WB; r0=8 (dbg).
REQ-029 SHALL cover this scenario: r1=3, r2=5; SUB rd=3 -> r3=0xFE; SLT rd=3, ra=1, rb=2 -> r3=1.
REQ-030 SHALL cover this scenario: r2=0; BZ ra=2 -> zflag=1, no register changes; r2=7, BZ -> zflag=0.
REQ-031 SHALL cover this scenario: op 101 -> done=1, done_err=1, alu_op=000 throughout, registers and zflag unchanged.
REQ-032 SHALL cover this scenario: ld_valid and in_valid together in IDLE -> load performed, in_ready=0, instruction accepted the next cycle; back-to-back in_valid held high -> accepts spaced 3 cycles apart.
REQ-033 SHALL cover this scenario: rst pulsed during ISSUE of ADD rd=0 -> no done, r0=0, state IDLE, in_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - opcode, state and sizing definitions shared by the sequencer and the ALU
package alu_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_ILL = 3'b101,
    OP_SLT = 3'b110,
    OP_BZ  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  // Only the arithmetic/logic ops produce a register result
  function automatic logic op_writes_reg(input op_e op);
    return (op != OP_ILL) && (op != OP_BZ);
  endfunction

endpackage

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - 4x8 register file, one write port, three combinational read ports
module gpr_file
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-state instruction sequencer driving an external 1-cycle ALU
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_instr,
  input  logic        ld_valid,
  input  logic [1:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_ans,
  input  logic        alu_zero,
  output logic        done,
  output logic        done_err,
  output logic        zflag,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  state_e      state;
  logic [8:0]  instr;
  op_e         cur_op;
  logic [1:0]  rd, ra, rb;
  logic        accept;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  ra_data, rb_data;

  assign cur_op = op_e'(instr[8:6]);
  assign rd     = instr[5:4];
  assign ra     = instr[3:2];
  assign rb     = instr[1:0];

  // A pending load steals the IDLE cycle from the instruction port
  assign in_ready = (state == ST_IDLE) && !ld_valid && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state == ST_IDLE && ld_valid) begin
      rf_we = 1'b1;
    end else if (state == ST_WB && op_writes_reg(cur_op)) begin
      rf_we    = 1'b1;
      rf_waddr = rd;
      rf_wdata = alu_ans;
    end
  end

  gpr_file u_gpr (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (ra),
    .ra_data  (ra_data),
    .rb_addr  (rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // The illegal opcode never reaches the ALU; it sees an idle ADD of zeros instead
  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (state == ST_ISSUE && cur_op != OP_ILL) begin
      alu_op = cur_op;
      alu_a  = ra_data;
      alu_b  = rb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      instr    <= '0;
      zflag    <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            instr <= in_instr;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state    <= ST_WB;
          done     <= 1'b1;
          done_err <= (cur_op == OP_ILL);
        end
        ST_WB: begin
          state <= ST_IDLE;
          if (cur_op == OP_BZ) begin
            zflag <= alu_zero;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - table-driven bench for alu_sequencer with a registered ALU model
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic       ld_valid;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_ans;
  logic       alu_zero;
  logic       done, done_err, zflag;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  alu_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ans  (alu_ans),
    .alu_zero (alu_zero),
    .done     (done),
    .done_err (done_err),
    .zflag    (zflag),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Downstream ALU: one register stage; BZ passes a through so zero tests r[ra]
  logic [7:0] alu_res;
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = alu_a + alu_b;
      3'b001:  alu_res = alu_a - alu_b;
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      3'b100:  alu_res = alu_a ^ alu_b;
      3'b110:  alu_res = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
      3'b111:  alu_res = alu_a;
      default: alu_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    alu_ans  <= alu_res;
    alu_zero <= (alu_res == 8'h00);
  end

  typedef struct packed {
    logic [2:0]      op;
    logic [1:0]      rd, ra, rb;
    logic [3:0][7:0] pre;
    logic [2:0]      x_op;
    logic [7:0]      x_a, x_b;
    logic            x_err;
    logic [3:0][7:0] post;
    logic            x_z;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [3:0][7:0] r4(input logic [7:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rd, ra, rb,
                              input logic [3:0][7:0] pre, input logic [2:0] x_op,
                              input logic [7:0] x_a, x_b, input logic x_err,
                              input logic [3:0][7:0] post, input logic x_z);
    vec_t v;
    v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.pre = pre;
    v.x_op = x_op; v.x_a = x_a; v.x_b = x_b; v.x_err = x_err;
    v.post = post; v.x_z = x_z;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [3:0][7:0] exp);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = i[1:0];
      #1;
      chk($sformatf("%s r%0d", tag, i), {24'd0, dbg_data}, {24'd0, exp[i]});
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; ld_valid = 1'b0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0;

    vecs[0] = mk(3'b000, 2'd0, 2'd1, 2'd2, r4(8'h00, 8'h05, 8'h03, 8'h00), 3'b000, 8'h05, 8'h03, 1'b0, r4(8'h08, 8'h05, 8'h03, 8'h00), 1'b0);
    vecs[1] = mk(3'b001, 2'd3, 2'd1, 2'd2, r4(8'h00, 8'h03, 8'h05, 8'h00), 3'b001, 8'h03, 8'h05, 1'b0, r4(8'h00, 8'h03, 8'h05, 8'hFE), 1'b0);
    vecs[2] = mk(3'b110, 2'd3, 2'd1, 2'd2, r4(8'h00, 8'h03, 8'h05, 8'hFE), 3'b110, 8'h03, 8'h05, 1'b0, r4(8'h00, 8'h03, 8'h05, 8'h01), 1'b0);
    vecs[3] = mk(3'b111, 2'd0, 2'd2, 2'd0, r4(8'h09, 8'h03, 8'h00, 8'h01), 3'b111, 8'h00, 8'h09, 1'b0, r4(8'h09, 8'h03, 8'h00, 8'h01), 1'b1);
    vecs[4] = mk(3'b101, 2'd0, 2'd1, 2'd1, r4(8'h09, 8'h03, 8'h00, 8'h01), 3'b000, 8'h00, 8'h00, 1'b1, r4(8'h09, 8'h03, 8'h00, 8'h01), 1'b1);
    vecs[5] = mk(3'b111, 2'd0, 2'd2, 2'd0, r4(8'h09, 8'h03, 8'h07, 8'h01), 3'b111, 8'h07, 8'h09, 1'b0, r4(8'h09, 8'h03, 8'h07, 8'h01), 1'b0);
    vecs[6] = mk(3'b010, 2'd1, 2'd0, 2'd3, r4(8'hF0, 8'h11, 8'h22, 8'h3C), 3'b010, 8'hF0, 8'h3C, 1'b0, r4(8'hF0, 8'h30, 8'h22, 8'h3C), 1'b0);
    vecs[7] = mk(3'b011, 2'd2, 2'd0, 2'd3, r4(8'hF0, 8'h11, 8'h22, 8'h3C), 3'b011, 8'hF0, 8'h3C, 1'b0, r4(8'hF0, 8'h11, 8'hFC, 8'h3C), 1'b0);
    vecs[8] = mk(3'b100, 2'd0, 2'd0, 2'd0, r4(8'hA5, 8'h01, 8'h02, 8'h03), 3'b100, 8'hA5, 8'hA5, 1'b0, r4(8'h00, 8'h01, 8'h02, 8'h03), 1'b0);
    vecs[9] = mk(3'b000, 2'd1, 2'd1, 2'd2, r4(8'h00, 8'hFF, 8'h02, 8'h00), 3'b000, 8'hFF, 8'h02, 1'b0, r4(8'h00, 8'h01, 8'h02, 8'h00), 1'b0);

    // Reset state
    tick(); tick();
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst done_err", {31'd0, done_err}, 32'd0);
    chk("rst zflag", {31'd0, zflag}, 32'd0);
    chk("rst alu_op", {29'd0, alu_op}, 32'd0);
    check_regs("rst", r4(8'h00, 8'h00, 8'h00, 8'h00));
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven single instructions
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) load(i[1:0], vecs[k].pre[i]);
      in_valid = 1'b1;
      in_instr = {vecs[k].op, vecs[k].rd, vecs[k].ra, vecs[k].rb};
      #1;
      chk($sformatf("v%0d in_ready", k), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d issue alu_op", k), {29'd0, alu_op}, {29'd0, vecs[k].x_op});
      chk($sformatf("v%0d issue alu_a", k), {24'd0, alu_a}, {24'd0, vecs[k].x_a});
      chk($sformatf("v%0d issue alu_b", k), {24'd0, alu_b}, {24'd0, vecs[k].x_b});
      chk($sformatf("v%0d issue done", k), {31'd0, done}, 32'd0);
      tick();
      chk($sformatf("v%0d wb done", k), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d wb done_err", k), {31'd0, done_err}, {31'd0, vecs[k].x_err});
      chk($sformatf("v%0d wb alu_op", k), {29'd0, alu_op}, 32'd0);
      chk($sformatf("v%0d wb in_ready", k), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("v%0d idle done", k), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d zflag", k), {31'd0, zflag}, {31'd0, vecs[k].x_z});
      check_regs($sformatf("v%0d", k), vecs[k].post);
    end

    // Load and instruction together: load wins, instruction accepted next cycle
    ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'h11;
    in_valid = 1'b1; in_instr = {3'b000, 2'd0, 2'd1, 2'd1};
    #1;
    chk("ld+in in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("after ld in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("ld+in issue alu_a", {24'd0, alu_a}, 32'h11);
    // Held in_valid: ld during ISSUE must be ignored, accepts land every third cycle
    ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'hEE;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b2b%0d in_ready", k), {31'd0, in_ready}, (k % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("b2b%0d done", k), {31'd0, done}, (k % 3 == 1) ? 32'd1 : 32'd0);
      if (k == 0) ld_valid = 1'b0;
      if (k == 5) in_valid = 1'b0;
      tick();
    end
    chk("b2b idle in_ready", {31'd0, in_ready}, 32'd1);
    check_regs("b2b", r4(8'h22, 8'h11, 8'h02, 8'h00));

    // Reset during ISSUE aborts the instruction
    load(2'd0, 8'h44); load(2'd1, 8'h05); load(2'd2, 8'h03);
    in_valid = 1'b1; in_instr = {3'b000, 2'd0, 2'd1, 2'd2};
    tick();
    in_valid = 1'b0;
    chk("abort issue alu_a", {24'd0, alu_a}, 32'h05);
    rst = 1'b1;
    #1;
    chk("abort rst in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("abort done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort alu_op", {29'd0, alu_op}, 32'd0);
    tick();
    chk("abort late done", {31'd0, done}, 32'd0);
    chk("abort zflag", {31'd0, zflag}, 32'd0);
    check_regs("abort", r4(8'h00, 8'h00, 8'h00, 8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
